// File: rtl/lsu_dbus_if.sv
// Data-bus handshake bundle between the load/store unit and memory.
//   dreq_valid     request valid (held until dresp_addr_ok)
//   dreq_addr      byte address of the access
//   dreq_size      0=1B 1=2B 2=4B 3=8B
//   dreq_strobe    byte-write enables, zero for loads
//   dreq_data      lane-shifted store data
//   dresp_addr_ok  request accepted
//   dresp_data_ok  read data valid / write complete
//   dresp_data     raw 8-byte-aligned read word
// master: the load/store unit; slave: the memory side.
interface lsu_dbus_if;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/lsu_dbus.sv
// Load/store unit sitting between execute and the data bus. One memory op per start pulse:
// checks alignment, issues a single bus request, then extracts and extends the load result.
// Ports:
//   clk, rst      clock; synchronous active-low reset
//   start         launch an op (only honoured while idle)
//   re, we        load / store select (both set means load)
//   addr          effective byte address
//   wdata         right-aligned store data
//   info          funct3 (size in [1:0], zero-extend in [2])
//   dbus          data-bus master port
//   rdata         extended load result, held until the next load completes
//   finish        one-cycle completion pulse
//   err           qualifies finish: misaligned access or response timeout
module lsu_dbus #(
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              re,
  input  logic              we,
  input  logic [63:0]       addr,
  input  logic [63:0]       wdata,
  input  logic [2:0]        info,
  lsu_dbus_if.master        dbus,
  output logic [63:0]       rdata,
  output logic              finish,
  output logic              err
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StFault} state_e;

  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYC) - 32'd1;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;

  logic [63:0] req_addr_q;
  logic [2:0]  req_size_q;
  logic [7:0]  req_strobe_q;
  logic [63:0] req_data_q;
  logic [2:0]  info_q;
  logic        load_q;
  logic [63:0] rdata_q;

  // Request fields decoded from the execute-stage inputs
  logic        launch;
  logic        aligned;
  logic [7:0]  mask;
  logic [7:0]  strobe_in;
  logic [63:0] data_in;

  assign launch = start && (re || we);

  always_comb begin
    aligned = 1'b1;
    mask    = 8'hFF;
    case (info[1:0])
      2'd0: begin aligned = 1'b1;               mask = 8'h01; end
      2'd1: begin aligned = ~addr[0];           mask = 8'h03; end
      2'd2: begin aligned = (addr[1:0] == 2'b0); mask = 8'h0F; end
      default: begin aligned = (addr[2:0] == 3'b0); mask = 8'hFF; end
    endcase
  end

  // Loads never write; re wins when both re and we are set
  assign strobe_in = re ? 8'h00 : (mask << addr[2:0]);
  assign data_in   = re ? 64'h0 : (wdata << {addr[2:0], 3'b000});

  // Load extraction from the aligned response word, using the latched offset and funct3
  logic [63:0] lane;
  logic [63:0] load_ext;

  assign lane = dbus.dresp_data >> {req_addr_q[2:0], 3'b000};

  always_comb begin
    load_ext = lane;
    case (info_q[1:0])
      2'd0: load_ext = info_q[2] ? {56'h0, lane[7:0]}  : {{56{lane[7]}}, lane[7:0]};
      2'd1: load_ext = info_q[2] ? {48'h0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      2'd2: load_ext = info_q[2] ? {32'h0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: load_ext = lane;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (launch) state_d = aligned ? StReq : StFault;
      end
      StReq: begin
        if (dbus.dresp_addr_ok) begin
          if (dbus.dresp_data_ok) begin
            state_d = StDone;
          end else begin
            state_d = StWait;
            cnt_d   = 32'd0;
          end
        end
      end
      StWait: begin
        if (dbus.dresp_data_ok) begin
          state_d = StDone;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == TimeoutLast)) begin
          state_d = StFault;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDone:  state_d = StIdle;
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= 32'd0;
      req_addr_q   <= 64'h0;
      req_size_q   <= 3'd0;
      req_strobe_q <= 8'h00;
      req_data_q   <= 64'h0;
      info_q       <= 3'd0;
      load_q       <= 1'b0;
      rdata_q      <= 64'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Fields are captured only for ops that will reach the bus
      if (state_q == StIdle && launch && aligned) begin
        req_addr_q   <= addr;
        req_size_q   <= {1'b0, info[1:0]};
        req_strobe_q <= strobe_in;
        req_data_q   <= data_in;
        info_q       <= info;
        load_q       <= re;
      end
      // Capture on the data_ok edge so rdata is already valid during the finish cycle
      if (state_d == StDone && load_q) begin
        rdata_q <= load_ext;
      end
    end
  end

  assign dbus.dreq_valid  = (state_q == StReq);
  assign dbus.dreq_addr   = req_addr_q;
  assign dbus.dreq_size   = req_size_q;
  assign dbus.dreq_strobe = req_strobe_q;
  assign dbus.dreq_data   = req_data_q;

  assign rdata  = rdata_q;
  assign finish = (state_q == StDone) || (state_q == StFault);
  assign err    = (state_q == StFault);

endmodule

// File: tb/tb_lsu_dbus.sv
// Directed bench for lsu_dbus: a small bus responder with programmable accept/data latency,
// hand-computed expected results, and one comparison task.
module tb_lsu_dbus;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [63:0] addr = 64'h0;
  logic [63:0] wdata = 64'h0;
  logic [2:0]  info = 3'd0;
  logic [63:0] rdata;
  logic        finish;
  logic        err;

  lsu_dbus_if bus ();

  lsu_dbus #(.TIMEOUT_CYC(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .re     (re),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .info   (info),
    .dbus   (bus),
    .rdata  (rdata),
    .finish (finish),
    .err    (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observations from the last run_op
  int          obs_fin;
  logic        obs_err;
  int          obs_reqs;
  logic        obs_stable;
  logic        obs_after;
  logic [63:0] obs_addr;
  logic [2:0]  obs_size;
  logic [7:0]  obs_strobe;
  logic [63:0] obs_data;

  // Launch one op at a negedge and respond: addr_ok on REQ cycle index addr_lat (0-based),
  // data_ok data_lat cycles after acceptance (0 = same cycle, <0 = never).
  // obs_fin counts negedges after the start negedge up to the one where finish is seen.
  task automatic run_op(input string tag, input logic r, input logic w, input logic [63:0] a,
                        input logic [63:0] wd, input logic [2:0] inf, input int addr_lat,
                        input int data_lat, input logic [63:0] resp);
    int   req_n;
    int   since;
    logic acc;
    logic done;
    req_n = 0; since = 0; acc = 1'b0; done = 1'b0;
    obs_fin = -1; obs_err = 1'b0; obs_stable = 1'b1; obs_after = 1'b0;
    obs_addr = 64'h0; obs_size = 3'd0; obs_strobe = 8'h0; obs_data = 64'h0;
    start = 1'b1; re = r; we = w; addr = a; wdata = wd; info = inf;
    bus.dresp_data = resp;
    @(negedge clk);
    start = 1'b0; re = 1'b0; we = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      bus.dresp_addr_ok = 1'b0;
      bus.dresp_data_ok = 1'b0;
      if (finish) begin
        obs_fin = cyc; obs_err = err; done = 1'b1;
      end else if (bus.dreq_valid) begin
        if (req_n == 0) begin
          obs_addr = bus.dreq_addr; obs_size = bus.dreq_size;
          obs_strobe = bus.dreq_strobe; obs_data = bus.dreq_data;
        end else if (bus.dreq_addr !== obs_addr || bus.dreq_size !== obs_size ||
                     bus.dreq_strobe !== obs_strobe || bus.dreq_data !== obs_data) begin
          obs_stable = 1'b0;
        end
        if (req_n == addr_lat) begin
          bus.dresp_addr_ok = 1'b1;
          bus.dresp_data_ok = (data_lat == 0);
          acc = 1'b1;
          since = 0;
        end
        req_n++;
      end else if (acc) begin
        since++;
        bus.dresp_data_ok = (since == data_lat);
      end
      if (!done) @(negedge clk);
    end
    obs_reqs = req_n;
    check_eq({tag, "_done"}, 64'(done), 64'd1);
    if (done) begin
      @(negedge clk);
      obs_after = finish;
    end
  endtask

  initial begin
    logic seen;
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b1;   // stray response during reset/idle must be ignored
    bus.dresp_data    = 64'hFFFF_FFFF_FFFF_FFFF;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 64'(bus.dreq_valid), 64'd0);
    check_eq("rst_addr", bus.dreq_addr, 64'h0);
    check_eq("rst_size", 64'(bus.dreq_size), 64'd0);
    check_eq("rst_strobe", 64'(bus.dreq_strobe), 64'd0);
    check_eq("rst_data", bus.dreq_data, 64'h0);
    check_eq("rst_rdata", rdata, 64'h0);
    check_eq("rst_finish", 64'(finish), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle_stray_fin", 64'(finish), 64'd0);
    bus.dresp_data_ok = 1'b0;
    @(negedge clk);

    // LD, addr_ok & data_ok in the first REQ cycle
    run_op("ld", 1'b1, 1'b0, 64'h8000_0010, 64'h0, 3'b011, 0, 0, 64'h1122_3344_5566_7788);
    check_eq("ld_fin", 64'(obs_fin), 64'd2);
    check_eq("ld_err", 64'(obs_err), 64'd0);
    check_eq("ld_rdata", rdata, 64'h1122_3344_5566_7788);
    check_eq("ld_addr", obs_addr, 64'h8000_0010);
    check_eq("ld_size", 64'(obs_size), 64'd3);
    check_eq("ld_strobe", 64'(obs_strobe), 64'd0);
    check_eq("ld_reqs", 64'(obs_reqs), 64'd1);
    check_eq("ld_pulse", 64'(obs_after), 64'd0);

    // LB / LBU at byte 3
    run_op("lb", 1'b1, 1'b0, 64'h8000_0003, 64'h0, 3'b000, 0, 0, 64'h0000_0000_8F00_0000);
    check_eq("lb_rdata", rdata, 64'hFFFF_FFFF_FFFF_FF8F);
    run_op("lbu", 1'b1, 1'b0, 64'h8000_0003, 64'h0, 3'b100, 0, 0, 64'h0000_0000_8F00_0000);
    check_eq("lbu_rdata", rdata, 64'h0000_0000_0000_008F);

    // SH at offset 6; store must leave rdata alone
    run_op("sh", 1'b0, 1'b1, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 3'b001, 0, 0,
           64'hDEAD_BEEF_DEAD_BEEF);
    check_eq("sh_size", 64'(obs_size), 64'd1);
    check_eq("sh_strobe", 64'(obs_strobe), 64'hC0);
    check_eq("sh_data", obs_data, 64'hBEEF_0000_0000_0000);
    check_eq("sh_err", 64'(obs_err), 64'd0);
    check_eq("sh_rdata", rdata, 64'h0000_0000_0000_008F);

    // SB at offset 7 with junk upper wdata; SD full word
    run_op("sb", 1'b0, 1'b1, 64'h8000_0007, 64'h1234_5678_FFFF_FFAA, 3'b000, 0, 0, 64'h0);
    check_eq("sb_strobe", 64'(obs_strobe), 64'h80);
    check_eq("sb_data", obs_data, 64'hAA00_0000_0000_0000);
    run_op("sd", 1'b0, 1'b1, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 3'b011, 0, 0, 64'h0);
    check_eq("sd_strobe", 64'(obs_strobe), 64'hFF);
    check_eq("sd_data", obs_data, 64'h0123_4567_89AB_CDEF);

    // LW with slow accept (5 REQ cycles) and data 2 cycles after accept
    run_op("lw_slow", 1'b1, 1'b0, 64'h8000_0004, 64'h0, 3'b010, 4, 2, 64'h89AB_CDEF_0123_4567);
    check_eq("slow_reqs", 64'(obs_reqs), 64'd5);
    check_eq("slow_stable", 64'(obs_stable), 64'd1);
    check_eq("slow_fin", 64'(obs_fin), 64'd8);
    check_eq("slow_pulse", 64'(obs_after), 64'd0);
    check_eq("slow_rdata", rdata, 64'hFFFF_FFFF_89AB_CDEF);

    // LH / LHU at offset 6
    run_op("lh", 1'b1, 1'b0, 64'h8000_0006, 64'h0, 3'b001, 0, 1, 64'h8001_0000_0000_0000);
    check_eq("lh_rdata", rdata, 64'hFFFF_FFFF_FFFF_8001);
    run_op("lhu", 1'b1, 1'b0, 64'h8000_0006, 64'h0, 3'b101, 1, 0, 64'h8001_0000_0000_0000);
    check_eq("lhu_rdata", rdata, 64'h0000_0000_0000_8001);

    // re&&we behaves as a load (LWU at offset 4)
    run_op("rw", 1'b1, 1'b1, 64'h8000_0004, 64'hFFFF_FFFF_FFFF_FFFF, 3'b110, 0, 0,
           64'h89AB_CDEF_0123_4567);
    check_eq("rw_strobe", 64'(obs_strobe), 64'd0);
    check_eq("rw_data", obs_data, 64'h0);
    check_eq("rw_rdata", rdata, 64'h0000_0000_89AB_CDEF);

    // Misaligned LW: fault without bus activity
    run_op("mis", 1'b1, 1'b0, 64'h8000_0002, 64'h0, 3'b010, 0, 0, 64'h5555_5555_5555_5555);
    check_eq("mis_fin", 64'(obs_fin), 64'd1);
    check_eq("mis_err", 64'(obs_err), 64'd1);
    check_eq("mis_reqs", 64'(obs_reqs), 64'd0);
    check_eq("mis_rdata", rdata, 64'h0000_0000_89AB_CDEF);

    // Timeout: accepted, never completes -> fault after 8 WAIT cycles
    run_op("to", 1'b1, 1'b0, 64'h8000_0018, 64'h0, 3'b011, 0, -1, 64'h6666_6666_6666_6666);
    check_eq("to_fin", 64'(obs_fin), 64'd10);
    check_eq("to_err", 64'(obs_err), 64'd1);
    check_eq("to_rdata", rdata, 64'h0000_0000_89AB_CDEF);

    // start with re=we=0 is ignored
    start = 1'b1; re = 1'b0; we = 1'b0;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      if (finish || bus.dreq_valid) seen = 1'b1;
      @(negedge clk);
    end
    check_eq("nop_ignored", 64'(seen), 64'd0);

    // Reset while waiting for data_ok aborts the op
    start = 1'b1; re = 1'b1; addr = 64'h8000_0020; info = 3'b011;
    @(negedge clk);
    start = 1'b0; re = 1'b0;
    bus.dresp_addr_ok = 1'b1;
    @(negedge clk);
    bus.dresp_addr_ok = 1'b0;
    check_eq("abort_in_wait", 64'(bus.dreq_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_eq("abort_addr", bus.dreq_addr, 64'h0);
    check_eq("abort_rdata", rdata, 64'h0);
    check_eq("abort_finish", 64'(finish), 64'd0);
    check_eq("abort_err", 64'(err), 64'd0);
    bus.dresp_data_ok = 1'b1;
    bus.dresp_data = 64'h7777_7777_7777_7777;
    @(negedge clk);
    bus.dresp_data_ok = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      if (finish) seen = 1'b1;
      @(negedge clk);
    end
    check_eq("abort_no_fin", 64'(seen), 64'd0);
    check_eq("abort_rdata2", rdata, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
